// File: rtl/kbd_matrix_writer.sv
// PS/2 set-2 scancode to 8x8 key-matrix writer: prefix decode, lookup, read-modify-write of one row bit.
// Optional KBD_EXT_PREFIX_EN: when defined, E0 sets the extended flag carried in MAP_CODE[8].
module kbd_matrix_writer #(
  parameter int ROWS        = 8,
  parameter int ACTIVE_HIGH = 1,
  parameter int SKIP_E1     = 7
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] CODE,
  input  logic       CODE_VALID,
  output logic       CODE_READY,
  input  logic       RELEASE_ALL,
  output logic [8:0] MAP_CODE,
  input  logic       MAP_HIT,
  input  logic [2:0] MAP_ROW,
  input  logic [2:0] MAP_COL,
  output logic [2:0] A,
  output logic       WR,
  output logic [7:0] DI,
  input  logic [7:0] DO
);

  localparam int            SKW       = (SKIP_E1 > 0) ? $clog2(SKIP_E1 + 1) : 1;
  localparam logic [SKW-1:0] SKIP_INIT = SKW'(SKIP_E1);
  localparam logic [2:0]    LAST_ROW  = 3'(ROWS - 1);
  localparam logic          PRESS_BIT = (ACTIVE_HIGH != 0);
  localparam logic [7:0]    IDLE_ROW  = (ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;

  typedef enum logic [2:0] {SWEEP, IDLE, LOOKUP, RD, WB} state_t;

  state_t         state_q, state_d;
  logic [2:0]     sweep_q;
  logic [2:0]     row_q;
  logic [2:0]     col_q;
  logic [2:0]     a_q;
  logic           ext_q;
  logic           brk_q;
  logic           op_brk_q;
  logic           pending_q;
  logic [SKW-1:0] skip_q;
  logic           accept;
  logic           byte_data;
  logic           byte_err;
  logic [7:0]     wb_data;

  assign CODE_READY = !RESET && (state_q == IDLE) && !pending_q;
  assign accept     = CODE_VALID && CODE_READY;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    byte_data = 1'b0;
    byte_err  = 1'b0;
    if (skip_q == '0) begin
      case (CODE)
        8'hE0, 8'hF0, 8'hE1: ;
        8'h00, 8'hFF:        byte_err  = 1'b1;
        default:             byte_data = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SWEEP:  if (sweep_q == LAST_ROW) state_d = IDLE;
      IDLE: begin
        if (pending_q)                  state_d = SWEEP;
        else if (accept && byte_data)   state_d = LOOKUP;
      end
      LOOKUP: state_d = MAP_HIT ? RD : IDLE;
      RD:     state_d = WB;
      WB:     state_d = IDLE;
      default: state_d = SWEEP;
    endcase
  end

  always_comb begin
    wb_data        = DO;
    wb_data[col_q] = op_brk_q ? ~PRESS_BIT : PRESS_BIT;
  end

  // A holds its last value outside SWEEP/RD/WB; reset masks every RAM strobe at once.
  always_comb begin
    A  = a_q;
    WR = 1'b0;
    DI = 8'h00;
    case (state_q)
      SWEEP: begin
        A  = sweep_q;
        WR = 1'b1;
        DI = IDLE_ROW;
      end
      RD: A = row_q;
      WB: begin
        A  = row_q;
        WR = 1'b1;
        DI = wb_data;
      end
      default: ;
    endcase
    if (RESET) begin
      A  = 3'd0;
      WR = 1'b0;
      DI = 8'h00;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= SWEEP;
      sweep_q   <= 3'd0;
      a_q       <= 3'd0;
      row_q     <= 3'd0;
      col_q     <= 3'd0;
      MAP_CODE  <= 9'd0;
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      op_brk_q  <= 1'b0;
      pending_q <= 1'b0;
      skip_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= A;

      if (state_q == SWEEP)
        sweep_q <= (sweep_q == LAST_ROW) ? 3'd0 : sweep_q + 3'd1;

      // A request arriving in the same cycle the sweep starts keeps the flag set.
      if (RELEASE_ALL || (accept && byte_err))
        pending_q <= 1'b1;
      else if (state_q == IDLE && pending_q)
        pending_q <= 1'b0;

      if (accept) begin
        if (skip_q != '0) begin
          skip_q <= skip_q - SKW'(1);
        end else begin
          case (CODE)
`ifdef KBD_EXT_PREFIX_EN
            8'hE0: ext_q <= 1'b1;
`else
            8'hE0: ext_q <= 1'b0;
`endif
            8'hF0: brk_q <= 1'b1;
            8'hE1: begin
              skip_q <= SKIP_INIT;
              ext_q  <= 1'b0;
              brk_q  <= 1'b0;
            end
            8'h00, 8'hFF: begin
              ext_q <= 1'b0;
              brk_q <= 1'b0;
            end
            default: MAP_CODE <= {ext_q, CODE};
          endcase
        end
      end

      if (state_q == LOOKUP) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
        if (MAP_HIT) begin
          row_q    <= MAP_ROW;
          col_q    <= MAP_COL;
          op_brk_q <= brk_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_kbd_matrix_writer.sv
// Scoreboard bench for kbd_matrix_writer: a byte-level reference model predicts RAM writes,
// MAP_CODE and CODE_READY latency; a monitor checks every WR strobe against the queue.
module tb_kbd_matrix_writer;

  localparam int         ROWS        = 8;
  localparam int         ACTIVE_HIGH = 1;
  localparam int         SKIP_E1     = 7;
  localparam logic [7:0] IDLE_ROW    = (ACTIVE_HIGH != 0) ? 8'h00 : 8'hFF;
`ifdef KBD_EXT_PREFIX_EN
  localparam bit EXT_EN = 1'b1;
`else
  localparam bit EXT_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] CODE = 8'h00;
  logic       CODE_VALID = 1'b0;
  logic       CODE_READY;
  logic       RELEASE_ALL = 1'b0;
  logic [8:0] MAP_CODE;
  logic       MAP_HIT;
  logic [2:0] MAP_ROW;
  logic [2:0] MAP_COL;
  logic [2:0] A;
  logic       WR;
  logic [7:0] DI;
  logic [7:0] DO;

  kbd_matrix_writer #(.ROWS(ROWS), .ACTIVE_HIGH(ACTIVE_HIGH), .SKIP_E1(SKIP_E1)) dut (
    .CLK(CLK), .RESET(RESET), .CODE(CODE), .CODE_VALID(CODE_VALID), .CODE_READY(CODE_READY),
    .RELEASE_ALL(RELEASE_ALL), .MAP_CODE(MAP_CODE), .MAP_HIT(MAP_HIT), .MAP_ROW(MAP_ROW),
    .MAP_COL(MAP_COL), .A(A), .WR(WR), .DI(DI), .DO(DO)
  );

  always #5 CLK = ~CLK;

  // Lookup table and row RAM with one-cycle registered read.
  logic       lut_hit [512];
  logic [2:0] lut_row [512];
  logic [2:0] lut_col [512];
  logic [7:0] ram [8];

  assign MAP_HIT = lut_hit[MAP_CODE];
  assign MAP_ROW = lut_row[MAP_CODE];
  assign MAP_COL = lut_col[MAP_CODE];

  always @(posedge CLK) begin
    if (WR === 1'b1) ram[A] <= DI;
    DO <= ram[A];
  end

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        mon_e;
  int         n_tests = 0;
  int         n_fail  = 0;

  bit         m_ext;
  bit         m_brk;
  int         m_skip;
  logic [8:0] m_map;
  logic [7:0] mat [8];
  logic [7:0] pool [8] = '{8'h1C, 8'h1D, 8'h12, 8'h75, 8'h6B, 8'h74, 8'h5A, 8'h29};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (WR === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_wr: got A=%0d DI=%02h, required no write", A, DI);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(A), 32'(mon_e.a));
        check("wr_data", 32'(DI), 32'(mon_e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_sweep();
    wr_t e;
    for (int i = 0; i < ROWS; i++) begin
      e.a = 3'(i);
      e.d = IDLE_ROW;
      exp_q.push_back(e);
      mat[i] = IDLE_ROW;
    end
  endtask

  task automatic model_reset();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_skip = 0;
    m_map  = 9'd0;
    push_sweep();
  endtask

  // Expected effect of one accepted byte; lat = negedges from accept until READY returns.
  task automatic model_byte(input logic [7:0] b, output int lat);
    logic [7:0] mask;
    logic [7:0] v;
    logic [2:0] r;
    bit         want_one;
    wr_t        e;
    lat = 1;
    if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) begin
      m_ext = EXT_EN;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      m_skip = SKIP_E1;
      m_ext  = 1'b0;
      m_brk  = 1'b0;
    end else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      push_sweep();
      lat = ROWS + 2;
    end else begin
      m_map = {m_ext, b};
      if (lut_hit[m_map]) begin
        r        = lut_row[m_map];
        mask     = 8'h01 << lut_col[m_map];
        want_one = (ACTIVE_HIGH != 0) ? !m_brk : m_brk;
        v        = want_one ? (mat[r] | mask) : (mat[r] & ~mask);
        e.a      = r;
        e.d      = v;
        exp_q.push_back(e);
        mat[r]   = v;
        lat      = 4;
      end else begin
        lat = 2;
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    @(negedge CLK);
    while (!CODE_READY && n < 500) begin
      @(negedge CLK);
      n++;
    end
    if (!CODE_READY) check("ready_timeout", 32'(CODE_READY), 32'd1);
  endtask

  // rel_req: 0 none, >0 pulse RELEASE_ALL in that cycle after accept, <0 random if in flight.
  task automatic send_byte(input logic [7:0] b, input int rel_req);
    int lat;
    int n;
    int rel_at;
    wait_ready();
    model_byte(b, lat);
    rel_at = 0;
    if (rel_req > 0) rel_at = rel_req;
    else if (rel_req < 0 && (lat == 2 || lat == 4)) rel_at = $urandom_range(1, lat - 1);
    if (rel_at > 0) begin
      push_sweep();
      lat += ROWS + 1;
    end
    CODE       = b;
    CODE_VALID = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
      CODE_VALID  = 1'b0;
      RELEASE_ALL = (n == rel_at);
      if (n == 1) check("map_code", 32'(MAP_CODE), 32'(m_map));
    end while (!CODE_READY && n < 200);
    RELEASE_ALL = 1'b0;
    check("ready_latency", 32'(n), 32'(lat));
  endtask

  task automatic reset_in_rd(input logic [7:0] b);
    int n;
    wait_ready();
    CODE       = b;
    CODE_VALID = 1'b1;
    @(posedge CLK);
    #1 CODE_VALID = 1'b0;
    @(posedge CLK);
    #1 RESET = 1'b1;
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CODE_READY && n < 200);
    check("reset_sweep_len", 32'(n), 32'(ROWS + 1));
    check("map_code_after_reset", 32'(MAP_CODE), 32'(m_map));
  endtask

  initial begin
    int         n;
    int         r;
    logic [7:0] b;

    for (int i = 0; i < 512; i++) begin
      lut_hit[i] = ($urandom_range(0, 3) != 0);
      lut_row[i] = 3'($urandom_range(0, 7));
      lut_col[i] = 3'($urandom_range(0, 7));
    end
    lut_hit[9'h01C] = 1'b1; lut_row[9'h01C] = 3'd3; lut_col[9'h01C] = 3'd2;
    lut_hit[9'h01D] = 1'b1; lut_row[9'h01D] = 3'd3; lut_col[9'h01D] = 3'd4;
    lut_hit[9'h075] = 1'b0;
    lut_hit[9'h175] = 1'b0;

    // Reset held several cycles: all strobes quiet, then one full sweep.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_wr", 32'(WR), 32'd0);
    check("rst_a", 32'(A), 32'd0);
    check("rst_di", 32'(DI), 32'd0);
    check("rst_ready", 32'(CODE_READY), 32'd0);
    check("rst_map_code", 32'(MAP_CODE), 32'd0);
    model_reset();
    @(posedge CLK);
    #1 RESET = 1'b0;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while (!CODE_READY && n < 200);
    check("init_sweep_len", 32'(n), 32'(ROWS + 1));

    // Make, break, re-make on row 3.
    send_byte(8'h1D, 0);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h1C, 0);
    send_byte(8'h1C, 0);

    // Extended code with a map miss; then the fake-shift pair.
    send_byte(8'hE0, 0);
    send_byte(8'h75, 0);
    send_byte(8'hE0, 0);
    send_byte(8'h12, 0);

    // Pause sequence tail is swallowed, next byte decodes normally (idempotent make).
    send_byte(8'hE1, 0);
    send_byte(8'h14, 0);
    send_byte(8'h77, 0);
    send_byte(8'hE1, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h14, 0);
    send_byte(8'hF0, 0);
    send_byte(8'h77, 0);
    send_byte(8'h1C, 0);

    // Release-all during WB, then an overrun byte, then reset in RD.
    send_byte(8'h1D, 3);
    send_byte(8'h1C, 0);
    send_byte(8'hFF, 0);
    send_byte(8'h1C, 0);
    send_byte(8'hF0, 0);
    reset_in_rd(8'h1C);
    send_byte(8'h1C, 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      b = 8'hF0;
      else if (r < 20) b = 8'hE0;
      else if (r < 22) b = 8'hE1;
      else if (r < 24) b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
      else if (r < 70) b = pool[$urandom_range(0, 7)];
      else             b = 8'($urandom_range(1, 254));
      send_byte(b, ($urandom_range(0, 9) == 0) ? -1 : 0);
    end

    repeat (20) @(negedge CLK);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
